// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the serial program loader.
package loader_pkg;

    localparam int unsigned INSTR_W_DEF   = 13;
    localparam int unsigned MAX_WORDS_DEF = 1000;
    localparam int unsigned BIT_CNT_W     = $clog2(INSTR_W_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRE    = 2'd1,
        SHIFT  = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/loader_fifo.sv
// Synchronous word buffer between the host and the shifter.
// empty and not_full are registered so they can feed outputs directly.
module loader_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             not_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             push;
    logic             pop;

    assign push      = wr_en && not_full;
    assign pop       = rd_en && !empty;
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    assign rd_data   = mem[rd_ptr];

    // Word storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            not_full <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_nxt;
            empty    <= (count_nxt == '0);
            not_full <= (count_nxt != CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/program_loader.sv
// Serial program transmitter for the one-bit processor's instruction-load port.
// Buffers host words and streams each one LSB first while proc_en is high.
// Optional macro PROGRAM_LOADER_PROC_RESET_EN adds a one-cycle proc_reset
// pulse (PRE state) ahead of the stream.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned INSTR_W    = INSTR_W_DEF,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MAX_WORDS  = MAX_WORDS_DEF,
    parameter int unsigned CNT_W      = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_data,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   words_sent,
    output logic               proc_en,
    output logic               proc_ser,
    output logic               proc_reset
);

    state_t                 state;
    logic [INSTR_W-1:0]     shreg;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [BIT_CNT_W-1:0]   bit_nxt;
    logic [INSTR_W-1:0]     fifo_head;
    logic                   fifo_empty;
    logic                   word_last;
    logic                   more_ok;
    logic                   pop;

    assign bit_nxt   = bit_cnt + BIT_CNT_W'(1);
    assign word_last = (bit_cnt == BIT_CNT_W'(INSTR_W - 1));
    // A follow-on word must already be buffered and fit under the word limit.
    assign more_ok   = !fifo_empty && ((32'(words_sent) + 32'd1) < MAX_WORDS);
    assign pop       = ((state == IDLE) && start && !fifo_empty) ||
                       ((state == SHIFT) && word_last && more_ok);

    loader_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (in_valid),
        .wr_data  (in_data),
        .rd_en    (pop),
        .rd_data  (fifo_head),
        .empty    (fifo_empty),
        .not_full (in_ready)
    );

`ifdef PROGRAM_LOADER_PROC_RESET_EN
    logic proc_reset_q;
    assign proc_reset = proc_reset_q;
`else
    assign proc_reset = 1'b0;
`endif

    // Load sequencer, shift register and registered processor-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            words_sent <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            proc_en    <= 1'b0;
            proc_ser   <= 1'b0;
`ifdef PROGRAM_LOADER_PROC_RESET_EN
            proc_reset_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        words_sent <= '0;
                        if (fifo_empty) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            shreg   <= fifo_head;
                            bit_cnt <= '0;
`ifdef PROGRAM_LOADER_PROC_RESET_EN
                            state        <= PRE;
                            proc_reset_q <= 1'b1;
`else
                            state    <= SHIFT;
                            proc_en  <= 1'b1;
                            proc_ser <= fifo_head[0];
`endif
                        end
                    end
                end
`ifdef PROGRAM_LOADER_PROC_RESET_EN
                PRE: begin
                    proc_reset_q <= 1'b0;
                    proc_en      <= 1'b1;
                    proc_ser     <= shreg[0];
                    state        <= SHIFT;
                end
`endif
                SHIFT: begin
                    if (!word_last) begin
                        bit_cnt  <= bit_nxt;
                        proc_ser <= shreg[bit_nxt];
                    end else begin
                        words_sent <= words_sent + CNT_W'(1);
                        if (more_ok) begin
                            shreg    <= fifo_head;
                            bit_cnt  <= '0;
                            proc_ser <= fifo_head[0];
                        end else begin
                            state    <= FINISH;
                            proc_en  <= 1'b0;
                            proc_ser <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
